// File: rtl/stream_shell_pkg.sv
// Shared definitions for the CIRCT stream shell.
//   - data_w():   total beat width from field count and field width
//   - field_at(): bit offset of field i inside a packed beat
//   - state_e:    input sequencer states
package stream_shell_pkg;

  function automatic int data_w(input int n_fields, input int field_w);
    return n_fields * field_w;
  endfunction

  // Beat width of the default configuration (8 fields x 64 bits).
  localparam int DEF_DATA_W = data_w(8, 64);

  // Width of the output framing length and beat counter.
  localparam int FRAME_W = 16;

  // Field i of a beat lives at [field_at(i, field_w) +: field_w].
  function automatic int field_at(input int i, input int field_w);
    return i * field_w;
  endfunction

  typedef enum logic {
    ST_CTRL = 1'b0,
    ST_DATA = 1'b1
  } state_e;

endpackage

// File: rtl/circt_shell_fifo.sv
// Synchronous FIFO buffering kernel output beats toward the host source.
// Ports:
//   clock, reset     : clock, synchronous active-high reset (flushes contents)
//   push, din        : write din when push is high and not full
//   pop              : drop the head entry when pop is high and not empty
//   full, empty      : occupancy flags
//   head             : current head entry (valid while !empty)
module circt_shell_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  import stream_shell_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/circt_stream_shell.sv
// Shell between a host AXI4-Stream pair and a CIRCT handshake kernel.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   s_axis_*                : host sink (tkeep ignored, full beats only)
//   m_axis_*                : host source, buffered, framed by pkt_beats
//   inCtrl_*, in0_*         : kernel control token and input data
//   outCtrl_*, out0_*       : kernel completion token and output data
//   pkt_beats               : output packet length in beats, 0 = unframed
//   cnt_sink/src/pkt_in/done: handshake statistics, wrap modulo 2^CNT_W
//
// Input sequencer:
//   state   | meaning
//   ST_CTRL | offer one inCtrl token, host sink stalled
//   ST_DATA | host sink passed straight through to in0 until tlast
module circt_stream_shell
  import stream_shell_pkg::*;
#(
  parameter int N_FIELDS   = 8,
  parameter int FIELD_W    = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  localparam int DATA_W    = data_w(N_FIELDS, FIELD_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                inCtrl_valid,
  input  logic                inCtrl_ready,
  output logic                in0_valid,
  input  logic                in0_ready,
  output logic [DATA_W-1:0]   in0_data,
  input  logic                outCtrl_valid,
  output logic                outCtrl_ready,
  input  logic                out0_valid,
  output logic                out0_ready,
  input  logic [DATA_W-1:0]   out0_data,
  input  logic [15:0]         pkt_beats,
  output logic [CNT_W-1:0]    cnt_sink,
  output logic [CNT_W-1:0]    cnt_src,
  output logic [CNT_W-1:0]    cnt_pkt_in,
  output logic [CNT_W-1:0]    cnt_done
);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FRAME_W-1:0]   pkt_len_q, pkt_len_d;
  logic [FRAME_W-1:0]   cur_len;
  logic [CNT_W-1:0]     cnt_sink_q, cnt_sink_d, cnt_src_q, cnt_src_d;
  logic [CNT_W-1:0]     cnt_pkt_q, cnt_pkt_d, cnt_done_q, cnt_done_d;
  logic                 sink_hs, ctrl_hs, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_W-1:0]    fifo_head;
  logic                 unused_tkeep;

  assign unused_tkeep = ^s_axis_tkeep;

  // Sequencer: handshake outputs are forced low while reset is held,
  // since the state register only clears at the next edge.
  always_comb begin
    state_d       = state_q;
    inCtrl_valid  = 1'b0;
    in0_valid     = 1'b0;
    s_axis_tready = 1'b0;
    in0_data      = s_axis_tdata;
    if (!reset) begin
      case (state_q)
        ST_CTRL: begin
          inCtrl_valid = 1'b1;
          if (inCtrl_ready) state_d = ST_DATA;
        end
        ST_DATA: begin
          in0_valid     = s_axis_tvalid;
          s_axis_tready = in0_ready;
          if (s_axis_tvalid && in0_ready && s_axis_tlast) state_d = ST_CTRL;
        end
        default: state_d = ST_CTRL;
      endcase
    end
  end

  assign sink_hs = s_axis_tvalid && s_axis_tready;
  assign ctrl_hs = inCtrl_valid && inCtrl_ready;

  assign out0_ready    = !reset && !fifo_full;
  assign push          = out0_valid && out0_ready;
  assign m_axis_tvalid = !reset && !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = fifo_head;
  assign m_axis_tkeep  = '1;
  assign outCtrl_ready = 1'b1;

  circt_shell_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (out0_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The first beat of a packet frames against the live pkt_beats; later
  // beats use the copy latched on that first pop.
  assign cur_len      = (beat_cnt_q == '0) ? pkt_beats : pkt_len_q;
  assign m_axis_tlast = (cur_len != '0) && (beat_cnt_q == cur_len - 16'd1);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_len_d  = pkt_len_q;
    if (pop) begin
      if (beat_cnt_q == '0) pkt_len_d = pkt_beats;
      if (m_axis_tlast || cur_len == '0) beat_cnt_d = '0;
      else                               beat_cnt_d = beat_cnt_q + 16'd1;
    end
    cnt_sink_d = cnt_sink_q + CNT_W'(sink_hs);
    cnt_src_d  = cnt_src_q  + CNT_W'(pop);
    cnt_pkt_d  = cnt_pkt_q  + CNT_W'(ctrl_hs);
    cnt_done_d = cnt_done_q + CNT_W'(outCtrl_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CTRL;
      beat_cnt_q <= '0;
      pkt_len_q  <= '0;
      cnt_sink_q <= '0;
      cnt_src_q  <= '0;
      cnt_pkt_q  <= '0;
      cnt_done_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_len_q  <= pkt_len_d;
      cnt_sink_q <= cnt_sink_d;
      cnt_src_q  <= cnt_src_d;
      cnt_pkt_q  <= cnt_pkt_d;
      cnt_done_q <= cnt_done_d;
    end
  end

  assign cnt_sink   = cnt_sink_q;
  assign cnt_src    = cnt_src_q;
  assign cnt_pkt_in = cnt_pkt_q;
  assign cnt_done   = cnt_done_q;

endmodule

// File: doc/circt_stream_shell.md
Name: circt_stream_shell

Overview:
- Parametrised shell between a host AXI4-Stream pair and a CIRCT-generated handshake kernel: `inCtrl`/`in0` on the sink side, `outCtrl`/`out0` on the source side.
- Replaces hand-wired per-field kernel hookup:
  - N_FIELDS lanes of FIELD_W bits.
  - One `inCtrl` token per input packet.
  - Buffered output path with programmable packet framing (`tlast`).
  - Handshake beat/packet statistics.
- Sits inside the per-vFPGA user logic, directly behind the host stream interfaces.

Parameters:
- N_FIELDS, 8, number of kernel data fields per beat.
- FIELD_W, 64, width of one field in bits; DATA_W = N_FIELDS*FIELD_W.
- FIFO_DEPTH, 8, output buffer entries; power of two, minimum 2.
- CNT_W, 32, width of statistics counters.

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: reset; synchronous, active-high.
- s_axis_tdata, in, DATA_W: host sink data.
- s_axis_tkeep, in, DATA_W/8: ignored (full beats only).
- s_axis_tlast, in, 1: end of input packet.
- s_axis_tvalid, in, 1: host sink valid.
- s_axis_tready, out, 1: host sink ready.
- m_axis_tdata, out, DATA_W: host source data.
- m_axis_tkeep, out, DATA_W/8: host source keep.
- m_axis_tlast, out, 1: end of output packet.
- m_axis_tvalid, out, 1: host source valid.
- m_axis_tready, in, 1: host source ready.
- inCtrl_valid, out, 1: kernel control token valid.
- inCtrl_ready, in, 1: kernel control token ready.
- in0_valid, out, 1: kernel input valid.
- in0_ready, in, 1: kernel input ready.
- in0_data, out, DATA_W: field i at bits [i*FIELD_W +: FIELD_W].
- outCtrl_valid, in, 1: kernel completion token valid.
- outCtrl_ready, out, 1: kernel completion token ready.
- out0_valid, in, 1: kernel output valid.
- out0_ready, out, 1: kernel output ready.
- out0_data, in, DATA_W: kernel output fields, same packing as in0_data.
- pkt_beats, in, 16: output packet length in beats; 0 = unframed.
- cnt_sink, out, CNT_W: accepted sink beats.
- cnt_src, out, CNT_W: accepted source beats.
- cnt_pkt_in, out, CNT_W: accepted inCtrl tokens.
- cnt_done, out, CNT_W: accepted outCtrl tokens.

Behaviour:
- Reset values:
  - Outputs: all valids 0, counters 0.
  - Input FSM in CTRL; FIFO empty; beat_cnt 0.
  - s_axis_tready 0 during reset.
- Input FSM, states CTRL and DATA:
  - CTRL:
    - inCtrl_valid=1; s_axis_tready=0; in0_valid=0.
    - On inCtrl_valid&inCtrl_ready, go to DATA next cycle and increment cnt_pkt_in.
  - DATA:
    - inCtrl_valid=0; in0_valid=s_axis_tvalid; s_axis_tready=in0_ready; in0_data=s_axis_tdata.
    - The DATA pass-through is combinational, zero latency.
    - On accepted beat with s_axis_tlast=1, go to CTRL next cycle.
  - First inCtrl_valid is driven in the first cycle after reset deasserts.
  - inCtrl_valid stays high until accepted and is never withdrawn.
- Output path:
  - out0_ready = !fifo_full.
  - Push on out0_valid&out0_ready.
  - m_axis_tvalid = !fifo_empty; m_axis_tdata = FIFO head.
  - Pop on m_axis_tvalid&m_axis_tready.
  - Latency: out0 accept to m_axis_tvalid is 1 cycle.
  - Simultaneous push and pop when full is not allowed (out0_ready=0 when full).
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - Full throughput, 1 beat/cycle, with m_axis_tready held high.
- Framing:
  - beat_cnt (16b) counts popped beats.
  - pkt_len is latched from pkt_beats on every pop with beat_cnt==0.
  - The first beat of a packet uses pkt_beats directly.
  - m_axis_tlast = (len!=0) && (beat_cnt==len-1), where len is the latched value, or pkt_beats when beat_cnt==0.
  - On a pop with tlast, beat_cnt returns to 0; otherwise it increments.
  - len==0: tlast is never set and beat_cnt stays 0.
  - len==1: every beat carries tlast.
- m_axis_tkeep is all ones.
- outCtrl_ready is tied to 1; each outCtrl_valid cycle increments cnt_done.
- Counters:
  - Each counter increments by 1 per handshake and wraps modulo 2^CNT_W.
  - cnt_sink counts s_axis handshakes; cnt_src counts m_axis handshakes.
- Reset asserted mid-packet: FSM returns to CTRL, FIFO is flushed, beat_cnt is cleared. No partial state is retained.

Decomposition:
- Shared package (stream_shell_pkg):
  - Localparam DATA_W helper.
  - State typedef enum {ST_CTRL, ST_DATA}.
  - Field slice function field_at(i).
- Sub-module circt_shell_fifo:
  - Synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push/pop/full/empty/head.
  - Uses clock/reset with the same polarity.
- The top-level instantiates circt_shell_fifo once.

Test Plan:
1. Release reset, kernel holds inCtrl_ready=1 -> inCtrl_valid=1 in first cycle; cnt_pkt_in=1; s_axis_tready follows in0_ready from the next cycle.
2. Send 4-beat packet with field i of beat b = b*16+i, tlast on beat 3 -> in0_data identical per beat, FSM back in CTRL, second inCtrl token issued, cnt_sink=4, cnt_pkt_in=2.
3. pkt_beats=3, kernel emits 7 beats, m_axis_tready=1 -> tlast on output beats 2 and 5 only; beat 6 has tlast=0; cnt_src=7.
4. m_axis_tready=0, kernel emits 10 beats with FIFO_DEPTH=8 -> out0_ready drops after 8 pushes; release ready -> all 10 beats delivered in order, none lost.
5. pkt_beats=0 with 5 beats -> tlast never asserted; then pkt_beats=1 -> every subsequent beat has tlast=1.
6. Assert reset for 1 cycle mid-packet, with FIFO holding 3 entries and beat_cnt=2 -> m_axis_tvalid=0, all counters 0, inCtrl_valid=1 on the first post-reset cycle.
